// File: rtl/am_mul_share_arbiter.sv
// Round-robin share of one external 8x8 approximate multiplier among NREQ lanes,
// with an operand stage and a result stage. Optional exact bypass: AM_EXACT_BYPASS_EN.
module am_mul_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NREQ-1:0]                        req_valid,
  output logic [NREQ-1:0]                        req_ready,
  input  logic [8*NREQ-1:0]                      req_x,
  input  logic [8*NREQ-1:0]                      req_y,
  input  logic [TAG_W*NREQ-1:0]                  req_tag,
  output logic [7:0]                             mul_x,
  output logic [7:0]                             mul_y,
  input  logic [15:0]                            mul_z,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [15:0]                            rsp_z,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
  output logic [TAG_W-1:0]                       rsp_tag,
`ifdef AM_EXACT_BYPASS_EN
  input  logic [NREQ-1:0]                        req_exact,
  output logic                                   rsp_exact,
`endif
  output logic                                   busy
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             r_v1, r_v2;
  logic [7:0]       r_x1, r_y1;
  logic [ID_W-1:0]  r_id1, r_id2, r_ptr;
  logic [TAG_W-1:0] r_tag1, r_tag2;
  logic [15:0]      r_z2;
  logic             r_ex1, r_ex2;

  logic             w_s1_en, w_s2_en, w_xfer, w_iso, w_gex;
  logic [NREQ-1:0]  w_gnt;
  logic [ID_W-1:0]  w_gidx, w_ptr_nxt;
  logic [7:0]       w_gx, w_gy;
  logic [TAG_W-1:0] w_gtag;
  logic [15:0]      w_prod;

  assign w_s2_en = !r_v2 | rsp_ready;
  assign w_s1_en = !r_v1 | w_s2_en;

  // Search from the pointer upward, wrapping; the grant is also the ready.
  always_comb begin
    int idx;
    idx    = 0;
    w_gnt  = '0;
    w_gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (w_s1_en && (w_gnt == '0) && req_valid[idx]) begin
        w_gnt[idx] = 1'b1;
        w_gidx     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_gx   = '0;
    w_gy   = '0;
    w_gtag = '0;
    w_gex  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt[j]) begin
        w_gx   = req_x[j*8 +: 8];
        w_gy   = req_y[j*8 +: 8];
        w_gtag = req_tag[j*TAG_W +: TAG_W];
`ifdef AM_EXACT_BYPASS_EN
        w_gex  = req_exact[j];
`endif
      end
    end
  end

  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;
  assign w_ptr_nxt = (w_gidx == ID_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

  // Exact-bypass requests keep the approximate multiplier inputs quiet.
  assign w_iso = r_v1 & ~r_ex1;
  assign mul_x = w_iso ? r_x1 : 8'd0;
  assign mul_y = w_iso ? r_y1 : 8'd0;

`ifdef AM_EXACT_BYPASS_EN
  assign w_prod = r_ex1 ? ({8'd0, r_x1} * {8'd0, r_y1}) : mul_z;
`else
  assign w_prod = mul_z;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_x1   <= '0;
      r_y1   <= '0;
      r_id1  <= '0;
      r_tag1 <= '0;
      r_ex1  <= 1'b0;
      r_ptr  <= '0;
    end else if (w_s1_en) begin
      r_v1 <= w_xfer;
      if (w_xfer) begin
        r_x1   <= w_gx;
        r_y1   <= w_gy;
        r_id1  <= w_gidx;
        r_tag1 <= w_gtag;
        r_ex1  <= w_gex;
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  // Result stage holds whenever a response is waiting, keeping rsp_* stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_z2   <= '0;
      r_id2  <= '0;
      r_tag2 <= '0;
      r_ex2  <= 1'b0;
    end else if (w_s2_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_z2   <= w_prod;
        r_id2  <= r_id1;
        r_tag2 <= r_tag1;
        r_ex2  <= r_ex1;
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_z     = r_z2;
  assign rsp_id    = r_id2;
  assign rsp_tag   = r_tag2;
  assign busy      = r_v1 | r_v2;
`ifdef AM_EXACT_BYPASS_EN
  assign rsp_exact = r_ex2;
`endif

endmodule

// File: tb/tb_am_mul_share_arbiter.sv
// Directed bench for am_mul_share_arbiter: table-driven round-robin vectors plus
// hand sequences for reset, latency, backpressure, isolation and exact bypass.
module tb_am_mul_share_arbiter;

  localparam int NREQ  = 4;
  localparam int TAG_W = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x, req_y;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic [7:0]        mul_x, mul_y;
  logic [15:0]       mul_z;
  logic              rsp_valid, rsp_ready;
  logic [15:0]       rsp_z;
  logic [1:0]        rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic              busy;
  logic              zero_z;
`ifdef AM_EXACT_BYPASS_EN
  logic [NREQ-1:0]   req_exact;
  logic              rsp_exact;
`endif

  logic [7:0]       xv [NREQ];
  logic [7:0]       yv [NREQ];
  logic [TAG_W-1:0] tv [NREQ];

  int n_chk  = 0;
  int n_fail = 0;

  am_mul_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
`ifdef AM_EXACT_BYPASS_EN
    .req_exact(req_exact), .rsp_exact(rsp_exact),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side multiplier: exact product unless forced to zero.
  assign mul_z = zero_z ? 16'h0000 : ({8'd0, mul_x} * {8'd0, mul_y});

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*8 +: 8]         = xv[i];
      req_y[i*8 +: 8]         = yv[i];
      req_tag[i*TAG_W +: TAG_W] = tv[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; checks happen 3ns later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0] vld;
    logic            rrdy;
    logic [NREQ-1:0] e_rdy;
    logic            e_rv;
    int              e_id;
  } vec_t;

  vec_t tbl [11];
  logic [15:0] bp_exp [3];
  logic [15:0] held_z;
  int          nrsp;

  initial begin
    // Round-robin: all four lanes valid for 8 cycles, then drain.
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b0, 0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 0};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 1};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 3};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 0};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 1};
    tbl[8]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 2};
    tbl[9]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 3};
    tbl[10] = '{4'h0, 1'b1, 4'b0000, 1'b0, 0};

    zero_z    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
`ifdef AM_EXACT_BYPASS_EN
    req_exact = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      xv[i] = 8'(10 + i*20);
      yv[i] = 8'(3 + i);
      tv[i] = TAG_W'(8 + i);
    end
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    next_cyc();

    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_z", 32'(rsp_z), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset mul_x", 32'(mul_x), 0);

    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].vld;
      rsp_ready = tbl[r].rrdy;
      #3;
      chk($sformatf("rr%0d req_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("rr%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].e_rv));
      if (tbl[r].e_rv) begin
        chk($sformatf("rr%0d rsp_id", r), 32'(rsp_id), 32'(tbl[r].e_id));
        chk($sformatf("rr%0d rsp_z", r), 32'(rsp_z),
            32'((10 + tbl[r].e_id*20) * (3 + tbl[r].e_id)));
        chk($sformatf("rr%0d rsp_tag", r), 32'(rsp_tag), 32'(8 + tbl[r].e_id));
      end
      next_cyc();
    end
    chk("rr idle busy", 32'(busy), 0);

    // Single request, lane 0: 200*150, tag 5, two-cycle latency.
    xv[0] = 8'd200; yv[0] = 8'd150; tv[0] = 4'd5;
    req_valid = 4'b0001;
    #3;
    chk("single req_ready", 32'(req_ready), 1);
    next_cyc();
    req_valid = '0;
    #3;
    chk("single mul_x", 32'(mul_x), 200);
    chk("single mul_y", 32'(mul_y), 150);
    chk("single early rsp_valid", 32'(rsp_valid), 0);
    next_cyc();
    #3;
    chk("single rsp_valid", 32'(rsp_valid), 1);
    chk("single rsp_z", 32'(rsp_z), 30000);
    chk("single rsp_id", 32'(rsp_id), 0);
    chk("single rsp_tag", 32'(rsp_tag), 5);
    next_cyc();
    #3;
    chk("single one response", 32'(rsp_valid), 0);
    next_cyc();

    // Backpressure: lane 1 streams 3 requests, sink stalls for 5 cycles.
    for (int k = 0; k < 3; k++) bp_exp[k] = 16'((k*37 + 11) * (k*5 + 200));
    nrsp = 0;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 10; c++) begin
        if (k < 3) begin
          req_valid = 4'b0010;
          xv[1] = 8'(k*37 + 11);
          yv[1] = 8'(k*5 + 200);
          tv[1] = 4'(k);
        end else begin
          req_valid = '0;
        end
        rsp_ready = (c >= 5);
        #3;
        if (c >= 2 && c <= 4) begin
          chk($sformatf("bp%0d req_ready full", c), 32'(req_ready), 0);
          chk($sformatf("bp%0d held valid", c), 32'(rsp_valid), 1);
          chk($sformatf("bp%0d held z", c), 32'(rsp_z), 32'(bp_exp[0]));
        end
        if (rsp_valid && rsp_ready) begin
          if (nrsp < 3) begin
            chk($sformatf("bp rsp%0d z", nrsp), 32'(rsp_z), 32'(bp_exp[nrsp]));
            chk($sformatf("bp rsp%0d tag", nrsp), 32'(rsp_tag), 32'(nrsp));
          end
          nrsp++;
        end
        if (req_ready[1]) k++;
        next_cyc();
      end
      chk("bp accepted count", 32'(k), 3);
      chk("bp response count", 32'(nrsp), 3);
    end

    // Isolation: idle for 10 cycles.
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      #3;
      if ((mul_x != 0) || (mul_y != 0) || busy)
        chk($sformatf("idle%0d mul_x|mul_y|busy", c), {23'd0, busy, mul_x | mul_y}, 0);
      else
        chk($sformatf("idle%0d quiet", c), {23'd0, busy, mul_x | mul_y}, 0);
      next_cyc();
    end

    // Reset mid-stream with both stages full.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    next_cyc();
    next_cyc();
    #3;
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("mid reset rsp_valid", 32'(rsp_valid), 0);
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset rsp_z", 32'(rsp_z), 0);
    chk("mid reset mul_x", 32'(mul_x), 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("post reset ptr grant", 32'(req_ready), 1);
    req_valid = 4'b0100;
    #2;
    chk("post reset lane2 grant", 32'(req_ready), 4);
    next_cyc();
    req_valid = '0;
    #3;
    chk("post reset no stale rsp", 32'(rsp_valid), 0);
    next_cyc();
    #3;
    chk("post reset first rsp valid", 32'(rsp_valid), 1);
    chk("post reset first rsp id", 32'(rsp_id), 2);
    chk("post reset first rsp z", 32'(rsp_z), 32'(xv[2] * yv[2]));
    next_cyc();

`ifdef AM_EXACT_BYPASS_EN
    // Exact bypass: approximate multiplier reads zero, result must still be exact.
    zero_z = 1'b1;
    xv[0] = 8'd255; yv[0] = 8'd255;
    req_exact = 4'b0001;
    req_valid = 4'b0001;
    next_cyc();
    req_valid = '0;
    req_exact = '0;
    #3;
    chk("exact busy", 32'(busy), 1);
    chk("exact mul_x", 32'(mul_x), 0);
    chk("exact mul_y", 32'(mul_y), 0);
    next_cyc();
    #3;
    chk("exact rsp_valid", 32'(rsp_valid), 1);
    chk("exact rsp_z", 32'(rsp_z), 65025);
    chk("exact rsp_exact", 32'(rsp_exact), 1);
    next_cyc();
    zero_z = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
